adda_log_adder: RTL and testbench

- Log-domain adder of the G.726 ADPCM quantizer/inverse-quantizer path (block ADDA).
- Adds the normalized log quantized difference DQLN to the scaled quantizer scale factor Y>>2. Produces the log-domain quantized difference DQL that feeds the antilog block.
- Main result is purely combinational, available in the same cycle as its inputs.
- A registered copy plus a wrap flag are provided for pipelined consumers.

---
 rtl/adda_log_adder.sv | 67 ++++++
 tb/tb_adda_log_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adda_log_adder.sv
// ADDA: log-domain adder of the G.726 quantizer path, DQL = (DQLN + (Y >> 2)) mod 4096.
// The combinational result feeds the antilog block; a captured copy serves pipelined consumers.
module adda_log_adder #(
  parameter int DQLN_W  = 12,
  parameter int Y_W     = 13,
  parameter int Y_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DQLN_W-1:0] DQLN,
  input  logic [Y_W-1:0]    Y,
  input  logic              EN,
  output logic [DQLN_W-1:0] DQL,
  output logic              DQL_WRAP,
  output logic [DQLN_W-1:0] DQL_Q,
  output logic              DQL_WRAP_Q,
  output logic              VALID_Q
);

  localparam int YS_W  = Y_W - Y_SHIFT;
  localparam int SUM_W = DQLN_W + 1;

  logic [YS_W-1:0]   ys;
  logic [SUM_W-1:0]  sum13;
  logic              unused_low_y;

  // The fractional bits of Y are dropped, not rounded.
  assign ys           = Y[Y_W-1:Y_SHIFT];
  assign unused_low_y = ^Y[Y_SHIFT-1:0];

  // DQLN is an unsigned pattern here; negative logs wrap through the carry-out.
  assign sum13    = {1'b0, DQLN} + {{(SUM_W-YS_W){1'b0}}, ys};
  assign DQL      = sum13[DQLN_W-1:0];
  assign DQL_WRAP = sum13[DQLN_W];

  logic [DQLN_W-1:0] dql_q, dql_d;
  logic              wrap_q, wrap_d;
  logic              valid_q, valid_d;

  always_comb begin
    dql_d   = dql_q;
    wrap_d  = wrap_q;
    valid_d = 1'b0;
    if (EN) begin
      dql_d   = DQL;
      wrap_d  = DQL_WRAP;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dql_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      dql_q   <= dql_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
    end
  end

  assign DQL_Q      = dql_q;
  assign DQL_WRAP_Q = wrap_q;
  assign VALID_Q    = valid_q;

endmodule

// File: tb/tb_adda_log_adder.sv
// Scoreboard bench for adda_log_adder: combinational DQL checked on the falling edge,
// registered copy checked the cycle after capture.
module tb_adda_log_adder;

  typedef struct packed {
    logic [11:0] dql;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] DQLN;
  logic [12:0] Y;
  logic        EN;
  logic [11:0] DQL;
  logic        DQL_WRAP;
  logic [11:0] DQL_Q;
  logic        DQL_WRAP_Q;
  logic        VALID_Q;

  int n_cmp = 0;
  int n_err = 0;

  exp_t comb_q[$];
  exp_t reg_q[$];

  adda_log_adder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .DQLN      (DQLN),
    .Y         (Y),
    .EN        (EN),
    .DQL       (DQL),
    .DQL_WRAP  (DQL_WRAP),
    .DQL_Q     (DQL_Q),
    .DQL_WRAP_Q(DQL_WRAP_Q),
    .VALID_Q   (VALID_Q)
  );

  always #5 clk = ~clk;

  // Reference arithmetic done in plain integers, independent of bit slicing.
  function automatic exp_t model(input logic [11:0] d, input logic [12:0] y);
    int s;
    exp_t e;
    s = int'(d) + (int'(y) / 4);
    e.dql  = 12'(s % 4096);
    e.wrap = (s >= 4096);
    return e;
  endfunction

  // Inputs change 1 ns after the rising edge.
  task automatic drive(input logic [11:0] d, input logic [12:0] y, input logic en, input logic rn);
    @(posedge clk);
    #1;
    DQLN    = d;
    Y       = y;
    EN      = en;
    reset_n = rn;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    EN      = 1'b0;
    DQLN    = 12'h000;
    Y       = 13'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (DQL_Q !== 12'h000) begin
      n_err++;
      $display("FAIL reset_dql_q: got %h expected 000", DQL_Q);
    end
    n_cmp++;
    if (DQL_WRAP_Q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wrap_q: got %b expected 0", DQL_WRAP_Q);
    end
    n_cmp++;
    if (VALID_Q !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid_q: got %b expected 0", VALID_Q);
    end
    $display("reset: DQL_Q=%h WRAP_Q=%b VALID_Q=%b", DQL_Q, DQL_WRAP_Q, VALID_Q);
  endtask

  task automatic test_comb_table();
    logic [11:0] td[5] = '{12'h000, 12'h100, 12'h100, 12'hFF0, 12'hFFF};
    logic [12:0] ty[5] = '{13'h0000, 13'h0880, 13'h0883, 13'h0220, 13'h1FFF};
    exp_t        te[5] = '{{12'h000, 1'b0}, {12'h320, 1'b0}, {12'h320, 1'b0},
                           {12'h078, 1'b1}, {12'h7FE, 1'b1}};
    exp_t        e;
    for (int i = 0; i < 5; i++) begin
      drive(td[i], ty[i], 1'b0, 1'b1);
      comb_q.push_back(te[i]);
      @(negedge clk);
      n_cmp++;
      if (comb_q.size() == 0) begin
        n_err++;
        $display("FAIL comb_table_empty: scoreboard empty at vector %0d", i);
      end else begin
        e = comb_q.pop_front();
        if ({DQL, DQL_WRAP} !== {e.dql, e.wrap}) begin
          n_err++;
          $display("FAIL comb_table[%0d]: DQLN=%h Y=%h got DQL=%h WRAP=%b expected DQL=%h WRAP=%b",
                   i, td[i], ty[i], DQL, DQL_WRAP, e.dql, e.wrap);
        end
      end
      $display("comb: DQLN=%h Y=%h -> DQL=%h WRAP=%b", td[i], ty[i], DQL, DQL_WRAP);
    end
  endtask

  task automatic test_registered();
    exp_t e;
    drive(12'h100, 13'h0880, 1'b1, 1'b1);
    reg_q.push_back('{12'h320, 1'b0});
    drive(12'hFF0, 13'h0220, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (reg_q.size() == 0) begin
      n_err++;
      $display("FAIL reg_capture_empty: scoreboard empty");
    end else begin
      e = reg_q.pop_front();
      if ({DQL_Q, DQL_WRAP_Q, VALID_Q} !== {e.dql, e.wrap, 1'b1}) begin
        n_err++;
        $display("FAIL reg_capture: got DQL_Q=%h WRAP_Q=%b VALID_Q=%b expected %h %b 1",
                 DQL_Q, DQL_WRAP_Q, VALID_Q, e.dql, e.wrap);
      end
    end
    $display("reg capture: DQL_Q=%h WRAP_Q=%b VALID_Q=%b", DQL_Q, DQL_WRAP_Q, VALID_Q);
    // EN low: registers hold while the combinational output moves on.
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({DQL_Q, DQL_WRAP_Q, VALID_Q} !== {12'h320, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reg_hold: got DQL_Q=%h WRAP_Q=%b VALID_Q=%b expected 320 0 0",
               DQL_Q, DQL_WRAP_Q, VALID_Q);
    end
    n_cmp++;
    if ({DQL, DQL_WRAP} !== {12'h078, 1'b1}) begin
      n_err++;
      $display("FAIL reg_hold_comb: got DQL=%h WRAP=%b expected 078 1", DQL, DQL_WRAP);
    end
    $display("reg hold: DQL_Q=%h VALID_Q=%b DQL=%h", DQL_Q, VALID_Q, DQL);
  endtask

  task automatic test_back_to_back(input int n);
    logic [11:0] d;
    logic [12:0] y;
    exp_t        e;
    for (int i = 0; i <= n; i++) begin
      d = 12'($urandom_range(0, 4095));
      y = 13'($urandom_range(0, 8191));
      if (i == 1) begin
        d = 12'hFFF;
        y = 13'h1FFF;
      end
      drive(d, y, (i < n), 1'b1);
      comb_q.push_back(model(d, y));
      @(negedge clk);
      n_cmp++;
      if (comb_q.size() == 0) begin
        n_err++;
        $display("FAIL b2b_comb_empty: cycle %0d", i);
      end else begin
        e = comb_q.pop_front();
        if ({DQL, DQL_WRAP} !== {e.dql, e.wrap}) begin
          n_err++;
          $display("FAIL b2b_comb[%0d]: DQLN=%h Y=%h got %h/%b expected %h/%b",
                   i, d, y, DQL, DQL_WRAP, e.dql, e.wrap);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (reg_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_reg_empty: cycle %0d", i);
        end else begin
          e = reg_q.pop_front();
          if ({DQL_Q, DQL_WRAP_Q, VALID_Q} !== {e.dql, e.wrap, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_reg[%0d]: got %h/%b/%b expected %h/%b/1",
                     i, DQL_Q, DQL_WRAP_Q, VALID_Q, e.dql, e.wrap);
          end
        end
      end
      if (i < n) reg_q.push_back(model(d, y));
      $display("b2b %0d: DQLN=%h Y=%h DQL=%h WRAP=%b DQL_Q=%h VALID_Q=%b",
               i, d, y, DQL, DQL_WRAP, DQL_Q, VALID_Q);
    end
  endtask

  task automatic test_reset_midstream();
    drive(12'h100, 13'h0880, 1'b1, 1'b1);
    drive(12'hFF0, 13'h0220, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({DQL_Q, VALID_Q} !== {12'h320, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_pre: got DQL_Q=%h VALID_Q=%b expected 320 1", DQL_Q, VALID_Q);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({DQL_Q, DQL_WRAP_Q, VALID_Q} !== {12'h000, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_reg: got DQL_Q=%h WRAP_Q=%b VALID_Q=%b expected 000 0 0",
               DQL_Q, DQL_WRAP_Q, VALID_Q);
    end
    n_cmp++;
    if ({DQL, DQL_WRAP} !== {12'h078, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_comb: got DQL=%h WRAP=%b expected 078 1", DQL, DQL_WRAP);
    end
    $display("reset midstream: DQL_Q=%h VALID_Q=%b DQL=%h WRAP=%b", DQL_Q, VALID_Q, DQL, DQL_WRAP);
    drive(12'h000, 13'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_comb_table();
    test_registered();
    test_back_to_back(40);
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
